// File: rtl/traffic_pkg.sv
// Shared constants and helpers for the intersection controller front end.
package traffic_pkg;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
   localparam int PED_OVERDUE_DEFAULT     = 25;  // same 25-cycle bound as the intersection's pedestrian liveness check
   localparam int WAIT_W                  = 8;

   localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

   function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
      return (v == WAIT_MAX) ? v : v + WAIT_W'(1);
   endfunction

endpackage

// File: rtl/traffic_input_debouncer.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw input.
// The level only changes after DEBOUNCE_CYCLES consecutive differing synchronised samples.
module traffic_input_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level
);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_level;
   logic [3:0] r_cnt;

   localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

   // The only place an asynchronous signal is sampled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_level <= 1'b0;
         r_cnt   <= 4'd0;
      end else if (r_sync2 == r_level) begin
         r_cnt <= 4'd0;
      end else if (r_cnt == CNT_LAST) begin
         r_level <= ~r_level;
         r_cnt   <= 4'd0;
      end else begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   assign level = r_level;

endmodule

// File: rtl/traffic_request_conditioner.sv
// Front end of the intersection controller: debounced turn sensor plus a sticky
// pedestrian request with a saturating age counter and an overdue flag.
module traffic_request_conditioner
   import traffic_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int OVERDUE_LIMIT   = PED_OVERDUE_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ped_button_raw,
   input  logic              turn_sensor_raw,
   input  logic              pedestrian_green,
   output logic              pedestrian_button,
   output logic              turn_sensor,
   output logic [WAIT_W-1:0] ped_wait,
   output logic              ped_overdue
);

   logic              w_ped_level;
   logic              w_turn_level;
   logic              w_press;
   logic              w_pend_nxt;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic              w_overdue_nxt;

   logic              r_ped_prev;
   logic              r_pending;
   logic              r_turn;
   logic [WAIT_W-1:0] r_wait;
   logic              r_overdue;

   traffic_input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ped_db (
      .clock (clock),
      .reset (reset),
      .raw   (ped_button_raw),
      .level (w_ped_level)
   );

   traffic_input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_turn_db (
      .clock (clock),
      .reset (reset),
      .raw   (turn_sensor_raw),
      .level (w_turn_level)
   );

   assign w_press = w_ped_level & ~r_ped_prev;

   // Grant has priority: a press landing with the grant is treated as already served.
   always_comb begin
      w_pend_nxt = r_pending;
      w_wait_nxt = r_wait;
      if (pedestrian_green) begin
         w_pend_nxt = 1'b0;
         w_wait_nxt = '0;
      end else if (r_pending) begin
         w_wait_nxt = sat_inc(r_wait);
      end else if (w_press) begin
         w_pend_nxt = 1'b1;
         w_wait_nxt = '0;
      end
      w_overdue_nxt = w_pend_nxt && (w_wait_nxt >= WAIT_W'(OVERDUE_LIMIT));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ped_prev <= 1'b0;
         r_pending  <= 1'b0;
         r_turn     <= 1'b0;
         r_wait     <= '0;
         r_overdue  <= 1'b0;
      end else begin
         r_ped_prev <= w_ped_level;
         r_pending  <= w_pend_nxt;
         r_turn     <= w_turn_level;
         r_wait     <= w_wait_nxt;
         r_overdue  <= w_overdue_nxt;
      end
   end

   assign pedestrian_button = r_pending;
   assign turn_sensor       = r_turn;
   assign ped_wait          = r_wait;
   assign ped_overdue       = r_overdue;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Directed bench for traffic_request_conditioner at default parameters.
module tb_traffic_request_conditioner;

   logic       clock;
   logic       reset;
   logic       ped_button_raw;
   logic       turn_sensor_raw;
   logic       pedestrian_green;
   logic       pedestrian_button;
   logic       turn_sensor;
   logic [7:0] ped_wait;
   logic       ped_overdue;

   int n_checks;
   int n_pass;

   traffic_request_conditioner dut (
      .clock             (clock),
      .reset             (reset),
      .ped_button_raw    (ped_button_raw),
      .turn_sensor_raw   (turn_sensor_raw),
      .pedestrian_green  (pedestrian_green),
      .pedestrian_button (pedestrian_button),
      .turn_sensor       (turn_sensor),
      .ped_wait          (ped_wait),
      .ped_overdue       (ped_overdue)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
   endtask

   // Advance n rising edges, sampling 1 time unit after each, and check the invariants.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         check("inv_wait_implies_req", {31'd0, (ped_wait == 8'd0) || pedestrian_button}, 32'd1);
         check("inv_overdue_implies_req", {31'd0, !ped_overdue || pedestrian_button}, 32'd1);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"},     {31'd0, pedestrian_button}, 32'd0);
      check({tag, "_turn"},    {31'd0, turn_sensor},       32'd0);
      check({tag, "_wait"},    {24'd0, ped_wait},          32'd0);
      check({tag, "_overdue"}, {31'd0, ped_overdue},       32'd0);
   endtask

   // Release, let the debounced level settle low, then press and land on the set edge.
   task automatic fresh_press(input string tag);
      ped_button_raw = 1'b0;
      step(10);
      ped_button_raw = 1'b1;
      step(7);
      check({tag, "_req_set"},  {31'd0, pedestrian_button}, 32'd1);
      check({tag, "_wait_set"}, {24'd0, ped_wait},          32'd0);
   endtask

   initial begin
      int exp_w;
      n_checks = 0;
      n_pass   = 0;
      reset            = 1'b1;
      ped_button_raw   = 1'b0;
      turn_sensor_raw  = 1'b0;
      pedestrian_green = 1'b0;
      #12;
      check_all_zero("reset");
      reset = 1'b0;
      step(2);
      check_all_zero("idle");

      // 1: press latency, raw driven just after edge 0
      ped_button_raw = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step(1);
         check("t1_req", {31'd0, pedestrian_button}, (k >= 7) ? 32'd1 : 32'd0);
         if (k == 7) check("t1_wait_e7", {24'd0, ped_wait}, 32'd0);
         if (k == 8) check("t1_wait_e8", {24'd0, ped_wait}, 32'd1);
      end

      // 3: grant at ped_wait=10, then a held button must not re-request
      step(9);
      check("t3_wait10", {24'd0, ped_wait}, 32'd10);
      pedestrian_green = 1'b1;
      step(1);
      pedestrian_green = 1'b0;
      check("t3_req_clr",  {31'd0, pedestrian_button}, 32'd0);
      check("t3_wait_clr", {24'd0, ped_wait},          32'd0);
      for (int k = 0; k < 15; k++) begin
         step(1);
         check("t3_held_no_req", {31'd0, pedestrian_button}, 32'd0);
      end
      fresh_press("t3_repress");
      pedestrian_green = 1'b1;
      step(1);
      pedestrian_green = 1'b0;
      check("t3_repress_clr", {31'd0, pedestrian_button}, 32'd0);

      // 2: glitches on both inputs never pass the debouncer
      ped_button_raw = 1'b0;
      step(10);
      ped_button_raw = 1'b1;
      step(3);
      ped_button_raw = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (k % 2 == 0) turn_sensor_raw = ~turn_sensor_raw;
         step(1);
         check("t2_req",  {31'd0, pedestrian_button}, 32'd0);
         check("t2_turn", {31'd0, turn_sensor},       32'd0);
      end
      turn_sensor_raw = 1'b0;
      step(10);

      // turn path: 7-edge latency both ways, not latched
      turn_sensor_raw = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step(1);
         check("turn_rise", {31'd0, turn_sensor}, (k >= 7) ? 32'd1 : 32'd0);
      end
      turn_sensor_raw = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step(1);
         check("turn_fall", {31'd0, turn_sensor}, (k >= 7) ? 32'd0 : 32'd1);
      end

      // 4: starvation, overdue from wait=25, saturation at 255
      fresh_press("t4");
      for (int k = 1; k <= 300; k++) begin
         step(1);
         exp_w = (k > 255) ? 255 : k;
         check("t4_wait",    {24'd0, ped_wait},          exp_w);
         check("t4_overdue", {31'd0, ped_overdue},       (exp_w >= 25) ? 32'd1 : 32'd0);
         check("t4_req",     {31'd0, pedestrian_button}, 32'd1);
      end
      pedestrian_green = 1'b1;
      step(1);
      pedestrian_green = 1'b0;
      check("t4_clr_wait",    {24'd0, ped_wait},    32'd0);
      check("t4_clr_overdue", {31'd0, ped_overdue}, 32'd0);

      // 5: press event coincides with the grant on edge 7
      ped_button_raw = 1'b0;
      step(10);
      ped_button_raw = 1'b1;
      step(6);
      check("t5_pre_req", {31'd0, pedestrian_button}, 32'd0);
      pedestrian_green = 1'b1;
      step(1);
      pedestrian_green = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("t5_req",  {31'd0, pedestrian_button}, 32'd0);
         check("t5_wait", {24'd0, ped_wait},          32'd0);
         step(1);
      end

      // 6: asynchronous reset mid-cycle while pending at wait=40
      fresh_press("t6");
      step(40);
      check("t6_wait40",   {24'd0, ped_wait},    32'd40);
      check("t6_overdue",  {31'd0, ped_overdue}, 32'd1);
      #2;
      reset          = 1'b1;
      ped_button_raw = 1'b0;
      #1;
      check_all_zero("t6_async");
      #2;
      reset = 1'b0;
      step(10);
      check_all_zero("t6_after");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/traffic_request_conditioner.md
Name: traffic_request_conditioner

Overview:
- Upstream front end of the intersection controller.
- Takes the raw, asynchronous pedestrian push-button and turn-lane vehicle sensor and synchronises and debounces both.
- Converts the pedestrian press into a sticky request that is held until the intersection grants pedestrian_green.
- Its outputs drive the intersection's pedestrian_button and turn_sensor inputs directly. It also exposes a request-age counter and an overdue flag for status and formal checks.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised cycles needed before a debounced level changes (legal range 1..15).
- OVERDUE_LIMIT, 25: ped_wait value at and above which ped_overdue asserts (legal range 1..255).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ped_button_raw  input  1  raw pedestrian push-button, asynchronous, may bounce.
- turn_sensor_raw  input  1  raw turn-lane loop detector, asynchronous, may bounce.
- pedestrian_green  input  1  grant feedback from the intersection.
- pedestrian_button  output  1  registered sticky pedestrian request to the intersection.
- turn_sensor  output  1  registered debounced turn-lane vehicle presence to the intersection.
- ped_wait  output  8  cycles the current request has been pending, saturating.
- ped_overdue  output  1  request pending for at least OVERDUE_LIMIT cycles.

Behaviour:
- Reset: clock is the single clock; reset is asynchronous and active-high. While reset is high:
  - all flops clear immediately;
  - pedestrian_button=0, turn_sensor=0, ped_wait=0, ped_overdue=0;
  - synchroniser, debounce counters and debounced levels = 0.
- Reset mid-operation: an assertion at any time drops a pending request with no further grant tracking. Release is recognised on the next rising edge.
- Synchroniser: a 2-flop chain per raw input. Metastability handling exists only here.
- Debounce, per input:
  - holds a debounced level d and a counter c, 4 bits;
  - if the synchronised value equals d, c <= 0;
  - otherwise c increments;
  - when c == DEBOUNCE_CYCLES-1 with the input still differing, d toggles and c <= 0.
  - Net effect: d changes only after DEBOUNCE_CYCLES consecutive differing samples.
- Latency: a clean raw edge reaches d on the (2+DEBOUNCE_CYCLES)th rising edge after first sampling.
- Turn path: turn_sensor <= d_turn, one register stage. End-to-end latency is 2+DEBOUNCE_CYCLES+1 edges (7 at default). The turn path is not latched.
- Pedestrian press event: a rising edge of d_ped (d_ped=1 and the previous d_ped=0). A held button produces exactly one event.
- Pending request (drives pedestrian_button), evaluated each edge in priority order:
  - pedestrian_green==1: pending <= 0. Clear wins over a simultaneous press.
  - else press event: pending <= 1.
  - else hold.
- A press whose event coincides with pedestrian_green is discarded as already served.
- Press-to-request latency is 2+DEBOUNCE_CYCLES+1 edges (7 at default).
- ped_wait:
  - 0 whenever pending is 0 and on the edge pending sets;
  - +1 on each edge where pending remains 1;
  - saturates at 255;
  - returns to 0 on the same edge pending clears.
- ped_overdue = pending && (ped_wait >= OVERDUE_LIMIT), registered together with ped_wait so both are consistent in the same cycle.
- Invariants for the bench:
  - ped_wait != 0 implies pedestrian_button;
  - ped_overdue implies pedestrian_button;
  - ped_wait <= 255.

Decomposition:
- Shared package traffic_pkg:
  - DEBOUNCE_CYCLES_DEFAULT=4;
  - PED_OVERDUE_DEFAULT=25, matching the 25-cycle pedestrian liveness bound used on the intersection;
  - WAIT_W=8.
- One sub-module, traffic_input_debouncer, instantiated twice:
  - parameter DEBOUNCE_CYCLES;
  - ports clock, reset, raw, level;
  - contains the 2-flop synchroniser plus the debounce counter.
- Press-edge detection, the pending flag and the wait counter stay in the top.

Test Plan:
1. Reset, then ped_button_raw=1 held from edge 0 with DEBOUNCE_CYCLES=4 -> pedestrian_button=0 through edge 6 and 1 from edge 7. ped_wait=0 at edge 7, 1 at edge 8.
2. Glitch: ped_button_raw high for 3 cycles then low; turn_sensor_raw toggling every 2 cycles for 40 cycles -> pedestrian_button and turn_sensor stay 0 throughout.
3. Grant: request pending with ped_wait=10, pedestrian_green=1 for one cycle -> next edge pedestrian_button=0, ped_wait=0. A further held button produces no new request until released and re-pressed.
4. Starvation: request pending, pedestrian_green held 0 for 300 cycles -> ped_overdue rises on the edge ped_wait reaches 25; ped_wait saturates at 255 and stays there.
5. Collision: the press event lands on the same edge as pedestrian_green=1 -> pending stays 0 and ped_wait stays 0.
6. Async reset asserted mid-cycle while pending with ped_wait=40 -> all outputs 0 immediately, before the next clock edge. After release with raw inputs low, outputs remain 0.
